// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
// The jump decode helper lives here so parent blocks can reuse it.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam logic [1:0] JUMP_OPC_DEFAULT = 2'b11;
  localparam logic [7:0] END_ADDR_DEFAULT = 8'd31;

  // Successor fetch address: a jump redirects into the low 64 addresses.
  function automatic logic [7:0] next_fetch_pc(input logic [7:0] cur_pc,
                                               input logic [7:0] data,
                                               input logic [1:0] jump_opc);
    if (data[7:6] == jump_opc) begin
      return {2'b00, data[5:0]};
    end
    return cur_pc + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a combinational ROM, resolves jumps
// locally and hands instructions to decode through a one-entry valid/ready slot.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [7:0] END_ADDR = END_ADDR_DEFAULT,
  parameter logic [1:0] JUMP_OPC = JUMP_OPC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       step,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] inst,
  output logic [7:0] inst_pc,
  output logic       inst_valid,
  input  logic       inst_ready,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic       halted,
  output logic [7:0] pc
);

  fetch_state_e state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [7:0]   inst_q, inst_d;
  logic [7:0]   inst_pc_q, inst_pc_d;
  logic         valid_q, valid_d;

  logic         transfer;
  logic         slot_free;
  logic         fetch_en;
  logic [7:0]   load_pc;

  assign transfer  = valid_q && inst_ready;
  assign slot_free = !valid_q || transfer;
  assign fetch_en  = (state_q == RUN) || ((state_q == IDLE) && step);
  assign load_pc   = next_fetch_pc(pc_q, imem_data, JUMP_OPC);

  // Priority: redirect, then run restart, then fetch/drain progress.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;

    if (transfer) begin
      valid_d = 1'b0;
    end

    if (redirect) begin
      valid_d = 1'b0;
      pc_d    = redirect_pc;
      if (state_q == DRAIN) begin
        state_d = RUN;
      end
    end else if (run && ((state_q == IDLE) || (state_q == HALT))) begin
      valid_d = 1'b0;
      pc_d    = 8'd0;
      state_d = RUN;
    end else if (fetch_en && slot_free) begin
      // A single step past the program end halts rather than fetching.
      if ((state_q == IDLE) && (pc_q > END_ADDR)) begin
        state_d = HALT;
      end else begin
        valid_d   = 1'b1;
        inst_d    = imem_data;
        inst_pc_d = pc_q;
        pc_d      = load_pc;
        if ((state_q == RUN) && (load_pc > END_ADDR)) begin
          state_d = DRAIN;
        end
      end
    end else if ((state_q == DRAIN) && slot_free) begin
      state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= 8'd0;
      inst_q    <= 8'd0;
      inst_pc_q <= 8'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances (default end address and end address 5)
// share stimulus and a ROM, each tracked by a transaction-level reference model.
module tb_fetch_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_HALT  = 3;

  typedef struct {
    int         mode;
    logic [7:0] pc;
    logic [7:0] inst;
    logic [7:0] ipc;
    bit         full;
  } mdl_t;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       runIn = 1'b0;
  logic       stepIn = 1'b0;
  logic       readyIn = 1'b1;
  logic       redirectIn = 1'b0;
  logic [7:0] redirectPc = 8'd0;

  logic [7:0] rom [256];

  logic [7:0] addrA, dataA, instA, instPcA, pcA;
  logic       validA, haltedA;
  logic [7:0] addrB, dataB, instB, instPcB, pcB;
  logic       validB, haltedB;

  int   errors = 0;
  int   checks = 0;
  bit   checking = 0;
  mdl_t mA, mB;
  logic [7:0] logA[$];
  logic [7:0] logB[$];

  assign dataA = rom[addrA];
  assign dataB = rom[addrB];

  always #5 clk = ~clk;

  fetch_ctrl dutA (
    .clk(clk), .reset_n(resetN), .run(runIn), .step(stepIn),
    .imem_addr(addrA), .imem_data(dataA), .inst(instA), .inst_pc(instPcA),
    .inst_valid(validA), .inst_ready(readyIn), .redirect(redirectIn),
    .redirect_pc(redirectPc), .halted(haltedA), .pc(pcA)
  );

  fetch_ctrl #(.END_ADDR(8'd5)) dutB (
    .clk(clk), .reset_n(resetN), .run(runIn), .step(stepIn),
    .imem_addr(addrB), .imem_data(dataB), .inst(instB), .inst_pc(instPcB),
    .inst_valid(validB), .inst_ready(readyIn), .redirect(redirectIn),
    .redirect_pc(redirectPc), .halted(haltedB), .pc(pcB)
  );

  // What one clock edge does to a fetcher, in terms of its observable mode and slot.
  function automatic mdl_t modelNext(input mdl_t m, input logic [7:0] endA,
                                     input logic [7:0] romByte);
    mdl_t n = m;
    bit taken = m.full && (inst_ready_now() == 1'b1);
    bit canTake = !m.full || taken;
    bit wantFetch;
    if (!resetN) begin
      n.mode = M_IDLE; n.pc = 8'd0; n.inst = 8'd0; n.ipc = 8'd0; n.full = 0;
      return n;
    end
    if (taken) n.full = 0;
    if (redirectIn) begin
      n.full = 0;
      n.pc = redirectPc;
      if (m.mode == M_DRAIN) n.mode = M_RUN;
      return n;
    end
    if (runIn && (m.mode == M_IDLE || m.mode == M_HALT)) begin
      n.mode = M_RUN; n.pc = 8'd0; n.full = 0;
      return n;
    end
    wantFetch = (m.mode == M_RUN) || (m.mode == M_IDLE && stepIn);
    if (wantFetch && canTake) begin
      if (m.mode == M_IDLE && m.pc > endA) begin
        n.mode = M_HALT;
        return n;
      end
      n.full = 1;
      n.inst = romByte;
      n.ipc  = m.pc;
      n.pc   = (romByte >= 8'hC0) ? (romByte & 8'h3F) : m.pc + 8'd1;
      if (m.mode == M_RUN && n.pc > endA) n.mode = M_DRAIN;
    end else if (m.mode == M_DRAIN && canTake) begin
      n.mode = M_HALT;
    end
    return n;
  endfunction

  function automatic logic inst_ready_now();
    return readyIn;
  endfunction

  task automatic reportCheck(input string name, input bit ok, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    reportCheck(name, act === exp, int'(act), int'(exp));
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    reportCheck(name, act === exp, int'(act), int'(exp));
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    reportCheck(name, act == exp, act, exp);
  endtask

  task automatic compareDut(input string tag, input mdl_t m, input logic [7:0] pcV,
                            input logic [7:0] addrV, input logic validV,
                            input logic [7:0] instV, input logic [7:0] ipcV,
                            input logic haltedV);
    checkOutput({tag, ".pc"}, pcV, m.pc);
    checkOutput({tag, ".imem_addr"}, addrV, m.pc);
    checkBit({tag, ".inst_valid"}, validV, m.full);
    checkBit({tag, ".halted"}, haltedV, m.mode == M_HALT);
    if (m.full) begin
      checkOutput({tag, ".inst"}, instV, m.inst);
      checkOutput({tag, ".inst_pc"}, ipcV, m.ipc);
    end
  endtask

  // Models and transfer logs advance on the same edge as the DUTs.
  always @(posedge clk) begin
    if (resetN && validA && readyIn) logA.push_back(instPcA);
    if (resetN && validB && readyIn) logB.push_back(instPcB);
    mA = modelNext(mA, 8'd31, rom[mA.pc]);
    mB = modelNext(mB, 8'd5, rom[mB.pc]);
  end

  // Every cycle, both DUTs are compared against their models just after the edge.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      compareDut("A", mA, pcA, addrA, validA, instA, instPcA, haltedA);
      compareDut("B", mB, pcB, addrB, validB, instB, instPcB, haltedB);
    end
  end

  task automatic applyStimulus(input bit r, input bit s, input bit rdy,
                               input bit rd, input logic [7:0] rpc);
    runIn = r; stepIn = s; readyIn = rdy; redirectIn = rd; redirectPc = rpc;
    @(negedge clk);
    runIn = 0; stepIn = 0; redirectIn = 0;
  endtask

  task automatic resetDut();
    resetN = 0; runIn = 0; stepIn = 0; redirectIn = 0; readyIn = 1;
    repeat (2) @(negedge clk);
    resetN = 1;
  endtask

  task automatic waitValidPc(input logic [7:0] target);
    int n = 0;
    while (!(validA && instPcA == target) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkBit("wait_for_slot_pc", validA && instPcA == target, 1'b1);
  endtask

  initial begin
    logic [7:0] held;
    for (int i = 0; i < 256; i++) rom[i] = 8'h40 | (i[7:0] & 8'h3F);
    rom[10] = 8'hC3;

    @(negedge clk);
    checking = 1;
    resetDut();
    checkOutput("reset_pc", pcA, 8'd0);
    checkBit("reset_valid", validA, 1'b0);
    checkBit("reset_halted", haltedA, 1'b0);
    checkOutput("reset_inst", instA, 8'd0);

    // Free run through a backward jump; instance B stops at address 5.
    logA.delete(); logB.delete();
    applyStimulus(1, 0, 1, 0, 8'd0);
    repeat (24) @(negedge clk);
    checkBit("loop_enough_transfers", logA.size() >= 16, 1'b1);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("loop_seq[%0d]", i), logA[i], (i <= 10) ? i[7:0] : 8'(i - 8));
    checkBit("loop_not_halted", haltedA, 1'b0);
    checkCount("end5_transfers", logB.size(), 6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("end5_seq[%0d]", i), logB[i], i[7:0]);
    checkBit("end5_halted", haltedB, 1'b1);

    // Back-pressure holds the slot and pc without loss or duplication.
    resetDut();
    logA.delete(); logB.delete();
    applyStimulus(1, 0, 1, 0, 8'd0);
    waitValidPc(8'd2);
    readyIn = 0;
    held = instA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("stall_inst_pc", instPcA, 8'd2);
      checkOutput("stall_inst", instA, held);
      checkOutput("stall_pc", pcA, 8'd3);
    end
    readyIn = 1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("stall_seq[%0d]", i), logA[i], i[7:0]);

    // Redirect flushes the slot holding pc 4.
    resetDut();
    applyStimulus(1, 0, 1, 0, 8'd0);
    waitValidPc(8'd4);
    applyStimulus(0, 0, 1, 1, 8'h07);
    checkBit("redir_valid", validA, 1'b0);
    checkOutput("redir_pc", pcA, 8'h07);
    logA.delete();
    repeat (4) @(negedge clk);
    checkOutput("redir_first", logA[0], 8'h07);

    // Single steps from IDLE; B halts once a step targets pc 6.
    resetDut();
    logA.delete(); logB.delete();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1, 0, 8'd0);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checkCount("step_count", logA.size(), 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("step_seq[%0d]", i), logA[i], i[7:0]);
    checkOutput("step_pc", pcA, 8'd3);
    checkBit("step_not_halted", haltedA, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 1, 0, 8'd0);
      @(negedge clk);
    end
    checkBit("step_past_end_halted", haltedB, 1'b1);
    checkCount("step_past_end_count", logB.size(), 6);
    checkOutput("step_a_pc", pcA, 8'd7);

    // Reset in the middle of a transfer discards the slot.
    resetDut();
    applyStimulus(1, 0, 1, 0, 8'd0);
    waitValidPc(8'd3);
    resetN = 0;
    logA.delete();
    @(negedge clk);
    resetN = 1;
    @(negedge clk);
    checkBit("midrst_valid", validA, 1'b0);
    checkOutput("midrst_pc", pcA, 8'd0);
    applyStimulus(1, 0, 1, 0, 8'd0);
    repeat (4) @(negedge clk);
    checkOutput("midrst_first", logA[0], 8'd0);

    // Randomized program and control traffic against the models.
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      resetN     = ($urandom_range(0, 99) != 0);
      runIn      = ($urandom_range(0, 99) < 5);
      stepIn     = ($urandom_range(0, 99) < 15);
      readyIn    = ($urandom_range(0, 3) != 0);
      redirectIn = ($urandom_range(0, 99) < 4);
      redirectPc = 8'($urandom_range(0, 40));
      @(negedge clk);
    end
    resetN = 1; runIn = 0; stepIn = 0; redirectIn = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter END_ADDR, default 8'd31: last valid instruction address; fetch SHALL stop after this address.
REQ-002 Parameter JUMP_OPC, default 2'b11: opcode in inst[7:6] that fetch_ctrl SHALL resolve as an unconditional jump.
REQ-003 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 run  in  1  one-cycle pulse: restart from address 0 and free-run.
REQ-006 step  in  1  one-cycle pulse: fetch exactly one instruction while not running.
REQ-007 imem_addr  out  8  address to the combinational instruction ROM; SHALL equal pc.
REQ-008 imem_data  in  8  ROM data for imem_addr, valid in the same cycle.
REQ-009 inst  out  8  registered instruction to decode.
REQ-010 inst_pc  out  8  address the held inst was fetched from.
REQ-011 inst_valid  out  1  output slot holds an instruction.
REQ-012 inst_ready  in  1  decode accepts; a transfer occurs when inst_valid && inst_ready.
REQ-013 redirect  in  1  taken-branch flush from execute.
REQ-014 redirect_pc  in  8  target address for redirect.
REQ-015 halted  out  1  high in state HALT.
REQ-016 pc  out  8  current fetch address.

Function
REQ-017 States: IDLE, RUN, DRAIN, HALT; states SHALL be encoded as a 2-bit enum.
REQ-018 The output slot SHALL load {imem_data, pc} when a fetch is enabled and the slot is empty or transferring in that cycle, giving 1-cycle latency from pc to inst_valid.
REQ-019 Fetch is enabled in RUN, and in IDLE only during a step pulse; it is never enabled in DRAIN or HALT.
REQ-020 On a load, pc SHALL become {2'b00, imem_data[5:0]} if imem_data[7:6]==JUMP_OPC, else pc+1; the jump instruction itself SHALL still be forwarded.
REQ-021 With inst_valid high and inst_ready low, inst, inst_pc and pc SHALL hold stable.
REQ-022 redirect SHALL take priority over load and transfer: next cycle inst_valid=0, pc=redirect_pc, and no instruction is loaded that cycle; the state is unchanged, except that DRAIN returns to RUN.
REQ-023 RUN→DRAIN when a load leaves pc > END_ADDR; DRAIN→HALT when the slot is empty or transferring.
REQ-024 run in IDLE or HALT SHALL set pc=0, clear the slot and enter RUN next cycle; run in RUN or DRAIN SHALL be ignored.
REQ-025 A step in IDLE with the slot full and not transferring SHALL be dropped; a step that would fetch at pc > END_ADDR SHALL go to HALT instead of loading.
REQ-026 If run and redirect coincide, redirect SHALL win and run is dropped.
REQ-027 pc arithmetic SHALL be 8-bit modulo; END_ADDR ≤ 8'd254 guarantees no wrap.

Reset
REQ-028 While reset_n=0 at a clock edge: state=IDLE, pc=0, inst=0, inst_pc=0, inst_valid=0, halted=0.
REQ-029 A reset asserted mid-transfer SHALL discard the slot contents without a handshake.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum, the JUMP_OPC default and the END_ADDR default.
REQ-031 The block SHALL be a single module with no sub-module; the ROM is instantiated by the parent, not inside fetch_ctrl.

Verification
REQ-032 Reset, run, inst_ready=1, ROM 0..10 sequential, addr 10=8'hC3: inst_pc sequence 0,1,…,10,3,4,…; halted stays 0.
REQ-033 ROM with no jumps, END_ADDR=5, run: exactly 6 transfers (pc 0–5), then halted=1 two cycles after the last load.
REQ-034 inst_ready=0 for 4 cycles at inst_pc=2: inst, inst_pc and pc=3 stay constant; no instruction is lost or duplicated.
REQ-035 redirect=1, redirect_pc=8'h07, issued while the slot holds pc 4: next cycle inst_valid=0 and pc=7; the next transfer has inst_pc=7.
REQ-036 From IDLE, three step pulses with inst_ready=1: transfers at inst_pc 0,1,2 only, state stays IDLE, pc=3.
REQ-037 reset_n=0 during a RUN transfer, then released, then run: first transfer has inst_pc=0, and the pre-reset instruction is never seen.
